// File: rtl/bram_readback_checker_if.sv
// ----------------------------------------------------------------------------
// bram_readback_checker_if
//   Read-only view of BRAM port B as seen by the readback checker.
//
//   Signals:
//     addrb  BRAM port B address            (checker -> BRAM)
//     enb    BRAM port B read enable        (checker -> BRAM)
//     doutb  BRAM port B read data          (BRAM -> checker)
//
//   Modports:
//     master  the checker side: drives addrb/enb, samples doutb
//     slave   the BRAM side: samples addrb/enb, drives doutb
// ----------------------------------------------------------------------------
interface bram_readback_checker_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) ();

    logic [ADDR_W-1:0] addrb;
    logic              enb;
    logic [DATA_W-1:0] doutb;

    modport master (
        output addrb,
        output enb,
        input  doutb
    );

    modport slave (
        input  addrb,
        input  enb,
        output doutb
    );

endinterface : bram_readback_checker_if

// File: rtl/bram_readback_checker.sv
// ----------------------------------------------------------------------------
// bram_readback_checker
//   Sweeps every address of BRAM port B once per start pulse and compares
//   each byte with the incrementing pattern written on port A:
//       expected(addr) = (addr[DATA_W-1:0] + PAT_OFFSET) mod 2^DATA_W
//   Reports pass/fail, mismatch count, first failing address and the last
//   byte compared. Port B write enable is tied low outside this block.
//
//   Parameters:
//     ADDR_W      BRAM address width (depth = 2^ADDR_W)
//     DATA_W      BRAM data width (must not exceed ADDR_W + DATA_W slicing
//                 assumptions; any DATA_W >= 1 works)
//     READ_LAT    cycles from addrb/enb to valid doutb, 1..3
//     PAT_OFFSET  constant added to the address pattern
//
//   Ports:
//     clk             system clock, rising edge
//     rst_n           asynchronous active-low reset
//     start           one-cycle pulse, accepted only when idle
//     bram            port B (addrb, enb out; doutb in)
//     busy            high from start acceptance until done
//     done            one-cycle pulse when the result is final
//     pass            last completed sweep had zero mismatches
//     err_count       mismatches in current/last sweep (saturating)
//     first_err_addr  address of the first mismatch, 0 if none
//     last_data       most recent compared doutb byte
// ----------------------------------------------------------------------------
module bram_readback_checker #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int READ_LAT   = 1,
    parameter int PAT_OFFSET = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    bram_readback_checker_if.master bram,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   last_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   ERR_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [DATA_W-1:0] PAT_OFF_V = DATA_W'(PAT_OFFSET);

    // Expected pattern byte for an address; the address is zero-extended
    // first so the low DATA_W bits exist even if DATA_W > ADDR_W.
    function automatic logic [DATA_W-1:0] expected_byte(input logic [ADDR_W-1:0] a);
        logic [ADDR_W+DATA_W-1:0] ext;
        ext = {{DATA_W{1'b0}}, a};
        return ext[DATA_W-1:0] + PAT_OFF_V;
    endfunction

    logic [1:0]        state_r;
    logic [ADDR_W-1:0] addrb_r;
    logic              enb_r;

    // Address/valid delay line matching the BRAM read latency; the last
    // stage lines up with doutb.
    logic [ADDR_W-1:0] addr_pipe_r [READ_LAT];
    logic [READ_LAT-1:0] vld_pipe_r;

    logic              start_acc_s;
    logic              cmp_vld_s;
    logic [ADDR_W-1:0] cmp_addr_s;
    logic              mismatch_s;
    logic              pipe_empty_s;

    assign bram.addrb = addrb_r;
    assign bram.enb   = enb_r;

    // Compare-stage decode: valid, aligned address and mismatch flag.
    always_comb begin
        start_acc_s  = 1'b0;
        cmp_vld_s    = vld_pipe_r[READ_LAT-1];
        cmp_addr_s   = addr_pipe_r[READ_LAT-1];
        mismatch_s   = 1'b0;
        pipe_empty_s = 1'b0;
        if (state_r == ST_IDLE) begin
            start_acc_s = start;
        end else begin
            start_acc_s = 1'b0;
        end
        if (cmp_vld_s) begin
            mismatch_s = (bram.doutb != expected_byte(cmp_addr_s));
        end else begin
            mismatch_s = 1'b0;
        end
        if (vld_pipe_r == {READ_LAT{1'b0}}) begin
            pipe_empty_s = 1'b1;
        end else begin
            pipe_empty_s = 1'b0;
        end
    end

    // Sweep FSM: address generation, read enable and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            addrb_r <= {ADDR_W{1'b0}};
            enb_r   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start_acc_s) begin
                        state_r <= ST_RUN;
                        addrb_r <= {ADDR_W{1'b0}};
                        enb_r   <= 1'b1;
                        busy    <= 1'b1;
                        pass    <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // The last address is issued once; addrb then holds so it
                    // never wraps back to 0 inside a sweep.
                    if (addrb_r == ADDR_LAST) begin
                        state_r <= ST_DRAIN;
                        enb_r   <= 1'b0;
                    end else begin
                        addrb_r <= addrb_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DRAIN: begin
                    // Wait for the final in-flight read to be compared so
                    // err_count is settled before pass is sampled.
                    if (pipe_empty_s) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        pass    <= (err_count == {(ADDR_W+1){1'b0}});
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    enb_r   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency delay line: tags each issued address with a valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_r <= {READ_LAT{1'b0}};
            for (int i = 0; i < READ_LAT; i++) begin
                addr_pipe_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            vld_pipe_r[0]  <= enb_r;
            addr_pipe_r[0] <= addrb_r;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                addr_pipe_r[i] <= addr_pipe_r[i-1];
            end
        end
    end

    // Result accumulation: cleared on start, updated on every valid compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count      <= {(ADDR_W+1){1'b0}};
            first_err_addr <= {ADDR_W{1'b0}};
            last_data      <= {DATA_W{1'b0}};
        end else if (start_acc_s) begin
            err_count      <= {(ADDR_W+1){1'b0}};
            first_err_addr <= {ADDR_W{1'b0}};
        end else if (cmp_vld_s) begin
            last_data <= bram.doutb;
            if (mismatch_s) begin
                if (err_count == {(ADDR_W+1){1'b0}}) begin
                    first_err_addr <= cmp_addr_s;
                end
                // Saturate rather than wrap; one sweep cannot exceed ERR_MAX.
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule : bram_readback_checker

// File: tb/tb_bram_readback_checker.sv
module tb_bram_readback_checker;

    logic clk;
    logic rst_n;
    logic start1, start2;
    logic busy1, done1, pass1, busy2, done2, pass2;
    logic [12:0] err1, err2;
    logic [11:0] first1, first2;
    logic [7:0]  last1, last2;

    int checks;
    int errors;
    int done_cnt1;
    int done_cnt2;
    logic sel;

    logic [7:0] mem1 [4096];
    logic [7:0] mem2 [4096];
    logic [7:0] stage2_r;

    bram_readback_checker_if #(.ADDR_W(12), .DATA_W(8)) bif1 ();
    bram_readback_checker_if #(.ADDR_W(12), .DATA_W(8)) bif2 ();

    bram_readback_checker #(.ADDR_W(12), .DATA_W(8), .READ_LAT(1), .PAT_OFFSET(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bram(bif1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_addr(first1), .last_data(last1)
    );

    bram_readback_checker #(.ADDR_W(12), .DATA_W(8), .READ_LAT(2), .PAT_OFFSET(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bram(bif2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_addr(first2), .last_data(last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models: one-stage for dut1, two-stage for dut2
    always @(posedge clk) begin
        if (bif1.enb) bif1.doutb <= mem1[bif1.addrb];
        if (bif2.enb) stage2_r <= mem2[bif2.addrb];
        bif2.doutb <= stage2_r;
    end

    always @(negedge clk) begin
        if (done1) done_cnt1 = done_cnt1 + 1;
        if (done2) done_cnt2 = done_cnt2 + 1;
    end

    logic        m_busy, m_done, m_pass, m_enb;
    logic [12:0] m_err;
    logic [11:0] m_first, m_addrb;
    logic [7:0]  m_last;
    assign m_busy  = sel ? busy2 : busy1;
    assign m_done  = sel ? done2 : done1;
    assign m_pass  = sel ? pass2 : pass1;
    assign m_enb   = sel ? bif2.enb : bif1.enb;
    assign m_err   = sel ? err2 : err1;
    assign m_first = sel ? first2 : first1;
    assign m_addrb = sel ? bif2.addrb : bif1.addrb;
    assign m_last  = sel ? last2 : last1;

    typedef struct packed {
        logic            sel;
        logic [1:0]      ncorr;
        logic [2:0][11:0] ca;
        logic [2:0][7:0]  cv;
        logic [12:0]     exp_lat;
        logic            exp_pass;
        logic [12:0]     exp_err;
        logic [11:0]     exp_first;
        logic [7:0]      exp_last;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_mem();
        for (int a = 0; a < 4096; a++) begin
            mem1[a] = 8'(a);
            mem2[a] = 8'(a);
        end
    endtask

    // Pulse start on the selected DUT and count cycles until done (bounded).
    task automatic run_sweep(input logic s, output int lat);
        sel = s;
        @(negedge clk);
        if (s) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        chk("busy_after_start", 32'(m_busy), 32'd1);
        chk("enb_after_start", 32'(m_enb), 32'd1);
        chk("addrb_after_start", 32'(m_addrb), 32'd0);
        lat = -1;
        for (int c = 1; c <= 6000; c++) begin
            @(posedge clk);
            #1;
            if (m_done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int busy_low;
        int d0;
        checks    = 0;
        errors    = 0;
        done_cnt1 = 0;
        done_cnt2 = 0;
        sel       = 1'b0;
        start1    = 1'b0;
        start2    = 1'b0;
        stage2_r  = 8'h00;
        rst_n     = 1'b0;
        fill_mem();

        vecs[0] = '{sel:1'b0, ncorr:2'd0, ca:'0, cv:'0, exp_lat:13'd4098,
                    exp_pass:1'b1, exp_err:13'd0, exp_first:12'h000, exp_last:8'hFF};
        vecs[1] = '{sel:1'b0, ncorr:2'd1, ca:{12'h000, 12'h000, 12'h123}, cv:{8'h00, 8'h00, 8'h00},
                    exp_lat:13'd4098, exp_pass:1'b0, exp_err:13'd1, exp_first:12'h123, exp_last:8'hFF};
        vecs[2] = '{sel:1'b0, ncorr:2'd3, ca:{12'hFFF, 12'h800, 12'h010}, cv:{8'h00, 8'h55, 8'hAA},
                    exp_lat:13'd4098, exp_pass:1'b0, exp_err:13'd3, exp_first:12'h010, exp_last:8'h00};
        vecs[3] = '{sel:1'b1, ncorr:2'd0, ca:'0, cv:'0, exp_lat:13'd4099,
                    exp_pass:1'b1, exp_err:13'd0, exp_first:12'h000, exp_last:8'hFF};
        vecs[4] = '{sel:1'b1, ncorr:2'd1, ca:{12'h000, 12'h000, 12'h000}, cv:{8'h00, 8'h00, 8'h01},
                    exp_lat:13'd4099, exp_pass:1'b0, exp_err:13'd1, exp_first:12'h000, exp_last:8'hFF};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_pass", 32'(pass1), 32'd0);
        chk("rst_enb", 32'(bif1.enb), 32'd0);
        chk("rst_addrb", 32'(bif1.addrb), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        chk("rst_first", 32'(first1), 32'd0);
        chk("rst_last", 32'(last1), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven sweeps
        for (int v = 0; v < 5; v++) begin
            fill_mem();
            for (int k = 0; k < 3; k++) begin
                if (k < int'(vecs[v].ncorr)) begin
                    if (vecs[v].sel) mem2[vecs[v].ca[k]] = vecs[v].cv[k];
                    else             mem1[vecs[v].ca[k]] = vecs[v].cv[k];
                end
            end
            run_sweep(vecs[v].sel, lat);
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            chk($sformatf("v%0d_pass", v), 32'(m_pass), 32'(vecs[v].exp_pass));
            chk($sformatf("v%0d_err_count", v), 32'(m_err), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_first_err", v), 32'(m_first), 32'(vecs[v].exp_first));
            chk($sformatf("v%0d_last_data", v), 32'(m_last), 32'(vecs[v].exp_last));
            chk($sformatf("v%0d_busy_at_done", v), 32'(m_busy), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", v), 32'(m_done), 32'd0);
            chk($sformatf("v%0d_pass_hold", v), 32'(m_pass), 32'(vecs[v].exp_pass));
            chk($sformatf("v%0d_enb_idle", v), 32'(m_enb), 32'd0);
            chk($sformatf("v%0d_addrb_hold", v), 32'(m_addrb), 32'hFFF);
        end

        // Start handling: restart at cycle 100 and start during DONE ignored
        fill_mem();
        sel = 1'b0;
        busy_low = 0;
        d0 = done_cnt1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 6000; c++) begin
            @(posedge clk);
            #1;
            if (c == 100) start1 = 1'b1;
            if (c == 101) start1 = 1'b0;
            if (done1) begin
                lat = c;
                break;
            end
            if (!busy1) busy_low = busy_low + 1;
        end
        chk("restart_latency", 32'(lat), 32'd4098);
        chk("restart_busy_low_cycles", 32'(busy_low), 32'd0);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        chk("start_in_done_busy", 32'(busy1), 32'd0);
        chk("start_in_done_enb", 32'(bif1.enb), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("restart_done_count", 32'(done_cnt1 - d0), 32'd1);
        chk("restart_busy_after", 32'(busy1), 32'd0);

        // Reset mid-sweep at address 0x400
        fill_mem();
        mem1[16] = 8'h00;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            if (bif1.addrb == 12'h400) begin
                lat = c;
                break;
            end
        end
        chk("reach_addr_400", 32'(lat), 32'd1024);
        chk("err_before_reset", 32'(err1), 32'd1);
        d0 = done_cnt1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy1), 32'd0);
        chk("async_rst_enb", 32'(bif1.enb), 32'd0);
        chk("async_rst_addrb", 32'(bif1.addrb), 32'd0);
        chk("async_rst_err", 32'(err1), 32'd0);
        chk("async_rst_first", 32'(first1), 32'd0);
        chk("async_rst_done", 32'(done1), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_done_after_reset", 32'(done_cnt1 - d0), 32'd0);
        chk("idle_after_reset", 32'(busy1), 32'd0);
        fill_mem();
        run_sweep(1'b0, lat);
        chk("post_reset_latency", 32'(lat), 32'd4098);
        chk("post_reset_pass", 32'(pass1), 32'd1);
        chk("post_reset_err", 32'(err1), 32'd0);
        chk("post_reset_last", 32'(last1), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bram_readback_checker
